// File: rtl/chdr_pkt_checker_if.sv
// Stream, settings-bus and status signals of chdr_pkt_checker bundled together.
// slave is the checker's view; master is the view of whatever drives it.
interface chdr_pkt_checker_if;
  logic [63:0] i_tdata;
  logic        i_tlast;
  logic        i_tvalid;
  logic        i_tready;
  logic [63:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [63:0] rb_data;
  logic        err_stb;
  logic [1:0]  err_code;

  modport slave (
    input  i_tdata, i_tlast, i_tvalid, o_tready, set_stb, set_addr, set_data,
    output i_tready, o_tdata, o_tlast, o_tvalid, rb_data, err_stb, err_code
  );

  modport master (
    output i_tdata, i_tlast, i_tvalid, o_tready, set_stb, set_addr, set_data,
    input  i_tready, o_tdata, o_tlast, o_tvalid, rb_data, err_stb, err_code
  );
endinterface

// File: rtl/chdr_pkt_checker.sv
// Passive CHDR packet checker: stream passes through combinationally while header length
// and sequence number are verified; errors pulse err_stb one cycle after the ending beat.
module chdr_pkt_checker #(
  parameter int SR_BASE           = 0,
  parameter bit SEQ_CHECK_DEFAULT = 1'b1
) (
  input  logic               bus_clk,
  input  logic               bus_rst,
  chdr_pkt_checker_if.slave  s
);
  typedef enum logic {ST_HEADER = 1'b0, ST_BODY = 1'b1} state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_rst_sync;
  logic [15:0] r_len;
  logic [11:0] r_seq, r_last_seq;
  logic [13:0] r_exp_lines, r_line_cnt;
  logic [31:0] r_pkt_cnt, r_len_err_cnt, r_seq_err_cnt;
  logic        r_seen, r_seq_chk_en, r_err_stb;
  logic [1:0]  r_err_code, r_rb_sel;
  logic [63:0] r_rb_data, w_rb_nxt;

  logic        w_run, w_beat, w_end, w_clr, w_ctrl_wr, w_sel_wr;
  logic [15:0] w_hdr_len, w_cur_len;
  logic [11:0] w_cur_seq;
  logic [13:0] w_hdr_exp, w_cur_exp, w_cur_lines, w_line_inc;
  logic        w_len_err, w_seq_err;
  logic        w_unused_ok;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  assign s.o_tdata  = s.i_tdata;
  assign s.o_tlast  = s.i_tlast;
  assign s.o_tvalid = s.i_tvalid;
  assign s.i_tready = s.o_tready;
  assign s.rb_data  = r_rb_data;
  assign s.err_stb  = r_err_stb;
  assign s.err_code = r_err_code;

  // Reset is released through two flops; nothing advances until the second clears.
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) r_rst_sync <= 2'b11;
    else         r_rst_sync <= {r_rst_sync[0], 1'b0};
  end

  assign w_run     = ~r_rst_sync[1];
  assign w_beat    = w_run & s.i_tvalid & s.o_tready;
  assign w_end     = w_beat & s.i_tlast;
  assign w_ctrl_wr = w_run & s.set_stb & (s.set_addr == 8'(SR_BASE));
  assign w_sel_wr  = w_run & s.set_stb & (s.set_addr == 8'(SR_BASE + 1));
  assign w_clr     = w_ctrl_wr & s.set_data[0];
  assign w_unused_ok = &{1'b0, s.set_data[31:2]};

  assign w_hdr_len  = s.i_tdata[47:32];
  assign w_hdr_exp  = {1'b0, w_hdr_len[15:3]} + {13'd0, |w_hdr_len[2:0]};
  assign w_line_inc = (&r_line_cnt) ? r_line_cnt : r_line_cnt + 14'd1;

  // A single-beat packet ends in HEADER, so its fields come straight off the bus.
  assign w_cur_len   = (r_state == ST_HEADER) ? w_hdr_len : r_len;
  assign w_cur_seq   = (r_state == ST_HEADER) ? s.i_tdata[59:48] : r_seq;
  assign w_cur_exp   = (r_state == ST_HEADER) ? w_hdr_exp : r_exp_lines;
  assign w_cur_lines = (r_state == ST_HEADER) ? 14'd1 : w_line_inc;

  assign w_len_err = (w_cur_len < 16'd8) | (w_cur_lines != w_cur_exp);
  assign w_seq_err = r_seq_chk_en & r_seen & (w_cur_seq != r_last_seq + 12'd1);

  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) r_state <= ST_HEADER;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_clr)       w_state_nxt = ST_HEADER;
    else if (w_beat) w_state_nxt = s.i_tlast ? ST_HEADER : ST_BODY;
  end

  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      r_len         <= 16'd0;
      r_seq         <= 12'd0;
      r_last_seq    <= 12'd0;
      r_exp_lines   <= 14'd0;
      r_line_cnt    <= 14'd0;
      r_pkt_cnt     <= 32'd0;
      r_len_err_cnt <= 32'd0;
      r_seq_err_cnt <= 32'd0;
      r_seen        <= 1'b0;
      r_seq_chk_en  <= SEQ_CHECK_DEFAULT;
      r_err_stb     <= 1'b0;
      r_err_code    <= 2'b00;
      r_rb_sel      <= 2'd0;
      r_rb_data     <= 64'd0;
    end else begin
      r_err_stb  <= 1'b0;
      r_err_code <= 2'b00;
      if (w_clr) begin
        r_pkt_cnt     <= 32'd0;
        r_len_err_cnt <= 32'd0;
        r_seq_err_cnt <= 32'd0;
        r_seen        <= 1'b0;
        r_line_cnt    <= 14'd0;
      end else if (w_beat) begin
        if (r_state == ST_HEADER) begin
          r_len       <= w_hdr_len;
          r_seq       <= s.i_tdata[59:48];
          r_exp_lines <= w_hdr_exp;
          r_line_cnt  <= 14'd1;
        end else begin
          r_line_cnt  <= w_line_inc;
        end
        if (w_end) begin
          r_err_stb  <= w_len_err | w_seq_err;
          r_err_code <= {w_seq_err, w_len_err};
          r_pkt_cnt  <= sat_inc32(r_pkt_cnt);
          if (w_len_err) r_len_err_cnt <= sat_inc32(r_len_err_cnt);
          if (w_seq_err) r_seq_err_cnt <= sat_inc32(r_seq_err_cnt);
          r_last_seq <= w_cur_seq;
          r_seen     <= 1'b1;
        end
      end
      if (w_ctrl_wr) r_seq_chk_en <= s.set_data[1];
      if (w_sel_wr)  r_rb_sel     <= s.set_data[1:0];
      if (w_run)     r_rb_data    <= w_rb_nxt;
    end
  end

  always_comb begin
    w_rb_nxt = 64'h0;
    case (r_rb_sel)
      2'd0:    w_rb_nxt = {r_len_err_cnt, r_pkt_cnt};
      2'd1:    w_rb_nxt = {r_seq_err_cnt, 20'h0, r_last_seq};
      2'd2:    w_rb_nxt = {48'h0, 2'b00, r_exp_lines};
      default: w_rb_nxt = 64'h0;
    endcase
  end
endmodule
